// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Glyph constants and segment bit order for the 7-seg display path.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam int SEG_W           = 7;
    localparam int SEG_GLYPH_COUNT = 16;

    // Segment bit order on the bus: {a,b,c,d,e,f,g}, a is the MSB, active-low
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b0000001;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b1001100;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0100000;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b0001111;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0000100;
    localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
    localparam logic [SEG_W-1:0] SEG_B     = 7'b1100000;
    localparam logic [SEG_W-1:0] SEG_C     = 7'b0110001;
    localparam logic [SEG_W-1:0] SEG_D     = 7'b1000010;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_F     = 7'b0111000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [SEG_W-1:0] glyph_of(input logic [3:0] value);
        logic [SEG_W-1:0] w_glyph;
        case (value)
            4'h0:    w_glyph = SEG_0;
            4'h1:    w_glyph = SEG_1;
            4'h2:    w_glyph = SEG_2;
            4'h3:    w_glyph = SEG_3;
            4'h4:    w_glyph = SEG_4;
            4'h5:    w_glyph = SEG_5;
            4'h6:    w_glyph = SEG_6;
            4'h7:    w_glyph = SEG_7;
            4'h8:    w_glyph = SEG_8;
            4'h9:    w_glyph = SEG_9;
            4'hA:    w_glyph = SEG_A;
            4'hB:    w_glyph = SEG_B;
            4'hC:    w_glyph = SEG_C;
            4'hD:    w_glyph = SEG_D;
            4'hE:    w_glyph = SEG_E;
            default: w_glyph = SEG_F;
        endcase
        return w_glyph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_encoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_encoder
// Description : Reverse map of a 7-seg pattern to {hit, blank, nibble}.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_encoder
    import seven_seg_pkg::*;
(
    input  logic [SEG_W-1:0] i_seg,
    output logic             o_hit,
    output logic             o_blank,
    output logic [3:0]       o_nibble
);

    // Glyphs are unique, so at most one table entry can match
    always_comb begin
        o_hit    = 1'b0;
        o_nibble = 4'h0;
        o_blank  = (i_seg == SEG_BLANK);
        for (int v = 0; v < SEG_GLYPH_COUNT; v++) begin
            if (i_seg == glyph_of(4'(v))) begin
                o_hit    = 1'b1;
                o_nibble = 4'(v);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_monitor
// Description : Passive monitor of a multiplexed 7-seg bus; captures stable digits.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_monitor
    import seven_seg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [N_DIGITS-1:0]   i_an,
    input  logic [SEG_W-1:0]      i_seg,
    output logic [4*N_DIGITS-1:0] o_digits,
    output logic [N_DIGITS-1:0]   o_digit_valid,
    output logic                  o_frame_valid,
    output logic                  o_err
);

    localparam int               CNT_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [N_DIGITS-1:0] r_an;
    logic [SEG_W-1:0]    r_seg;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_captured;
    logic [N_DIGITS-1:0] r_seen;

    logic                w_qualify;
    logic                w_same;
    logic [N_DIGITS-1:0] w_sel;
    logic [N_DIGITS-1:0] w_seen_acc;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_captured_next;
    logic                w_capture;
    logic                w_hit;
    logic                w_blank;
    logic [3:0]          w_nibble;

    assign w_sel      = ~i_an;
    assign w_qualify  = $onehot(w_sel);
    assign w_same     = (i_an == r_an) && (i_seg == r_seg);
    assign w_seen_acc = r_seen | w_sel;

    // The incoming pair is compared against the previous pair in the same edge,
    // so the capture lands STABLE_CYCLES-1 edges after the first sample edge.
    always_comb begin
        w_cnt_next      = r_cnt;
        w_captured_next = r_captured;
        w_capture       = 1'b0;
        if (!w_qualify) begin
            w_cnt_next      = '0;
            w_captured_next = 1'b0;
        end else if (w_same) begin
            if (r_cnt != c_cnt_max) begin
                w_cnt_next = r_cnt + c_cnt_one;
            end
        end else begin
            w_cnt_next      = c_cnt_one;
            w_captured_next = 1'b0;
        end
        if (w_qualify && (w_cnt_next == c_cnt_max) && !w_captured_next) begin
            w_capture       = 1'b1;
            w_captured_next = 1'b1;
        end
    end

    seven_seg_encoder u_encoder (
        .i_seg    (i_seg),
        .o_hit    (w_hit),
        .o_blank  (w_blank),
        .o_nibble (w_nibble)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_an          <= '1;
            r_seg         <= '1;
            r_cnt         <= '0;
            r_captured    <= 1'b0;
            r_seen        <= '0;
            o_digits      <= '0;
            o_digit_valid <= '0;
            o_frame_valid <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            r_an          <= i_an;
            r_seg         <= i_seg;
            r_cnt         <= w_cnt_next;
            r_captured    <= w_captured_next;
            o_frame_valid <= 1'b0;
            o_err         <= 1'b0;
            if (w_capture) begin
                for (int k = 0; k < N_DIGITS; k++) begin
                    if (w_sel[k]) begin
                        o_digits[4*k +: 4] <= w_hit ? w_nibble : 4'h0;
                        o_digit_valid[k]   <= w_hit;
                    end
                end
                o_err <= !w_hit && !w_blank;
                if (&w_seen_acc) begin
                    o_frame_valid <= 1'b1;
                    r_seen        <= '0;
                end else begin
                    r_seen <= w_seen_acc;
                end
            end
        end
    end

endmodule
`default_nettype wire
